// File: rtl/enc_vel_sched_pkg.sv
// enc_vel_sched_pkg: shared word layouts and FSM encoding for the velocity scheduler.
`default_nettype none

package enc_vel_sched_pkg;

    localparam int OVF      = 31;
    localparam int DIR      = 30;
    localparam int PER_MSB  = 21;

    localparam int VEL_CMP  = 31;
    localparam int VEL_DIR  = 30;
    localparam int VEL_QMSB = 29;

    localparam int DIV_ITERS = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DIV   = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic               ovf;
        logic               dir;
        logic [PER_MSB:0]   per;
    } snap_t;

endpackage

`default_nettype wire

// File: rtl/enc_serial_div.sv
// enc_serial_div: 32/22-bit restoring divider, one quotient bit per clock, MSB first.
`default_nettype none

module enc_serial_div
    import enc_vel_sched_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [21:0] divisor,
    output logic [31:0] quotient,
    output logic        done
);

    logic [21:0] rem_q;
    logic [31:0] quo_q;
    logic [21:0] dvs_q;
    logic [5:0]  cnt_q;

    logic [22:0] w_shift;
    logic [22:0] w_sub;
    logic        w_ge;

    // Dividend bits are shifted out of quo_q while quotient bits shift in behind them.
    always_comb begin
        w_shift = {rem_q, quo_q[31]};
        w_ge    = (w_shift >= {1'b0, dvs_q});
        w_sub   = w_shift - {1'b0, dvs_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= 6'(DIV_ITERS);
        end else if (cnt_q != 6'd0) begin
            rem_q <= w_ge ? w_sub[21:0] : w_shift[21:0];
            quo_q <= {quo_q[30:0], w_ge};
            cnt_q <= cnt_q - 6'd1;
        end
    end

    // Marks the cycle whose closing edge produces the final quotient bit.
    assign done     = (cnt_q == 6'd1);
    assign quotient = quo_q;

endmodule

`default_nettype wire

// File: rtl/enc_vel_sched.sv
// enc_vel_sched: coherent period snapshot plus one shared divider computing NUMERATOR/period per channel.
`default_nettype none

module enc_vel_sched
    import enc_vel_sched_pkg::*;
#(
    parameter int          NUM_CHAN  = 4,
    parameter logic [31:0] NUMERATOR = 32'd3072000,
    parameter int          QW        = 30
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample,
    input  logic [NUM_CHAN-1:0]     en,
    input  logic [NUM_CHAN*32-1:0]  period_in,
    output logic [NUM_CHAN*32-1:0]  vel_out,
    output logic                    vel_valid,
    output logic                    busy,
    output logic [7:0]              overrun_cnt
);

    localparam int CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

    state_e         state_q, state_d;
    snap_t          snap_q [NUM_CHAN];
    snap_t          w_in   [NUM_CHAN];
    logic [31:0]    vel_q  [NUM_CHAN];
    logic [CW-1:0]  ch_q;
    logic           pending_q, pending_d;
    logic [7:0]     ovr_q, ovr_d;

    snap_t          w_cur;
    logic           w_qual, w_last, w_take, w_sat;
    logic           w_div_start, w_div_done;
    logic [31:0]    w_quo;
    logic [29:0]    w_qfield;

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        assign w_in[i]            = {period_in[32*i+OVF], period_in[32*i+DIR], period_in[32*i +: PER_MSB+1]};
        assign vel_out[32*i +: 32] = vel_q[i];
    end

    assign w_cur  = snap_q[ch_q];
    assign w_qual = en[ch_q] && !w_cur.ovf && (w_cur.per != '0);
    assign w_last = (ch_q == CW'(NUM_CHAN - 1));
    assign w_take = ((state_q == ST_IDLE) && (sample || pending_q)) ||
                    ((state_q == ST_DONE) && pending_q);

    enc_serial_div u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (w_div_start),
        .dividend (NUMERATOR),
        .divisor  (w_cur.per),
        .quotient (w_quo),
        .done     (w_div_done)
    );

    always_comb begin
        w_sat    = ((w_quo >> QW) != 32'd0);
        w_qfield = '0;
        w_qfield[QW-1:0] = w_sat ? {QW{1'b1}} : w_quo[QW-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_take) state_d = ST_LOAD;
            ST_LOAD:  if (w_qual) state_d = ST_DIV;
                      else        state_d = w_last ? ST_DONE : ST_LOAD;
            ST_DIV:   if (w_div_done) state_d = ST_STORE;
            ST_STORE: state_d = w_last ? ST_DONE : ST_LOAD;
            ST_DONE:  state_d = pending_q ? ST_LOAD : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        vel_valid   = (state_q == ST_DONE);
        busy        = (state_q != ST_IDLE);
        w_div_start = (state_q == ST_LOAD) && w_qual;
    end

    // A request arriving while busy is parked once; any further request is dropped and counted.
    always_comb begin
        pending_d = pending_q;
        ovr_d     = ovr_q;
        if (state_q == ST_IDLE) begin
            if (w_take) pending_d = 1'b0;
        end else begin
            if ((state_q == ST_DONE) && pending_q) pending_d = 1'b0;
            if (sample) begin
                if (pending_q) begin
                    if (ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
                end else begin
                    pending_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= 1'b0;
            ovr_q     <= '0;
            ch_q      <= '0;
            for (int i = 0; i < NUM_CHAN; i++) begin
                snap_q[i] <= '0;
                vel_q[i]  <= '0;
            end
        end else begin
            pending_q <= pending_d;
            ovr_q     <= ovr_d;
            if (w_take) begin
                ch_q <= '0;
                for (int i = 0; i < NUM_CHAN; i++) snap_q[i] <= w_in[i];
            end else if (state_q == ST_LOAD && !w_qual) begin
                vel_q[ch_q] <= {1'b0, w_cur.dir, 30'd0};
                if (!w_last) ch_q <= ch_q + CW'(1);
            end else if (state_q == ST_STORE) begin
                vel_q[ch_q] <= {1'b1, w_cur.dir, w_qfield};
                if (!w_last) ch_q <= ch_q + CW'(1);
            end
        end
    end

    assign overrun_cnt = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_enc_vel_sched.sv
// tb_enc_vel_sched: scoreboarded directed test of the velocity scheduler.
`default_nettype none

module tb_enc_vel_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         sample;
    logic [3:0]   en;
    logic [127:0] period_in;
    logic [127:0] vel_out;
    logic         vel_valid, busy;
    logic [7:0]   overrun_cnt;

    logic         sample2;
    logic [0:0]   en2;
    logic [31:0]  period2;
    logic [31:0]  vel2;
    logic         valid2, busy2;
    logic [7:0]   ovr2;

    enc_vel_sched dut (
        .clk(clk), .reset(reset), .sample(sample), .en(en), .period_in(period_in),
        .vel_out(vel_out), .vel_valid(vel_valid), .busy(busy), .overrun_cnt(overrun_cnt)
    );

    enc_vel_sched #(.NUM_CHAN(1), .NUMERATOR(32'hFFFFFFFF), .QW(30)) dut_sat (
        .clk(clk), .reset(reset), .sample(sample2), .en(en2), .period_in(period2),
        .vel_out(vel2), .vel_valid(valid2), .busy(busy2), .overrun_cnt(ovr2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int n_valid = 0, exp_valid = 0, n_valid2 = 0, exp_valid2 = 0;

    typedef struct packed {
        logic [127:0] w;
        int           k;
        int           lat;
    } exp_t;

    exp_t        q1[$];
    logic [31:0] q2[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pw(input bit ovf, input bit dir, input int per);
        logic [31:0] p;
        p = per;
        return {ovf, dir, 8'd0, p[21:0]};
    endfunction

    initial begin : mon1
        exp_t e;
        forever begin
            @(negedge clk);
            if (vel_valid === 1'b1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    for (int i = 0; i < 4; i++)
                        chk($sformatf("vel%0d", i), vel_out[32*i +: 32], e.w[32*i +: 32]);
                    if (e.lat > 0) chk("latency", cyc - e.k + 1, e.lat);
                end
                n_valid++;
            end
        end
    end

    initial begin : mon2
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (valid2 === 1'b1) begin
                if (q2.size() == 0) begin
                    chk("unexpected_valid_sat", 32'd1, 32'd0);
                end else begin
                    e = q2.pop_front();
                    chk("vel_sat", vel2, e);
                end
                n_valid2++;
            end
        end
    end

    task automatic pulse(output int k);
        @(posedge clk); #1 sample = 1'b1;
        @(posedge clk); #1 sample = 1'b0;
        k = cyc;
    endtask

    task automatic push(input logic [127:0] w, input int k, input int lat);
        exp_t e;
        e.w = w; e.k = k; e.lat = lat;
        q1.push_back(e);
        exp_valid++;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((n_valid < exp_valid || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n_valid < exp_valid || busy) chk("timeout", n_valid, exp_valid);
    endtask

    localparam logic [127:0] EXP_T1 = {32'h80000001, 32'hC0000040, 32'h802EE000, 32'hC00003E8};

    task automatic set_t1();
        en        = 4'hF;
        period_in = {pw(0, 0, 3072000), pw(0, 1, 48000), pw(0, 0, 1), pw(0, 1, 3072)};
    endtask

    initial begin : stim
        int k;
        int low;
        logic [31:0] sat_per [3];
        logic [31:0] sat_exp [3];

        reset = 1'b0; sample = 1'b0; en = '0; period_in = '0;
        sample2 = 1'b0; en2 = 1'b1; period2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vel", {31'd0, |vel_out}, 32'd0);
        chk("rst_valid", {31'd0, vel_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovr", {24'd0, overrun_cnt}, 32'd0);
        @(negedge clk) reset = 1'b1;

        // all channels qualified
        set_t1();
        pulse(k);
        push(EXP_T1, k, 137);
        @(negedge clk);
        chk("busy_sweep", {31'd0, busy}, 32'd1);
        wait_done(400);

        // overflow, zero period and disabled channels are skipped
        en        = 4'b0111;
        period_in = {pw(0, 0, 10), pw(0, 1, 0), pw(1, 1, 5), pw(0, 0, 3072)};
        pulse(k);
        push({32'h00000000, 32'h40000000, 32'h40000000, 32'h800003E8}, k, 38);
        wait_done(400);

        // one pending request runs back-to-back
        set_t1();
        pulse(k);
        push(EXP_T1, k, 137);
        repeat (10) @(posedge clk);
        pulse(k);
        push(EXP_T1, k, 0);
        low = 0;
        for (int n = 0; n < 600 && n_valid < exp_valid; n++) begin
            @(negedge clk);
            if (!busy && n_valid < exp_valid) low++;
        end
        chk("busy_gap", low, 0);
        wait_done(400);
        chk("ovr_pending", {24'd0, overrun_cnt}, 32'd0);

        // third and fourth requests are dropped
        pulse(k);
        push(EXP_T1, k, 137);
        repeat (5) @(posedge clk);
        pulse(k);
        push(EXP_T1, k, 0);
        pulse(k);
        pulse(k);
        wait_done(800);
        chk("ovr_dropped", {24'd0, overrun_cnt}, 32'd2);

        // period_in churn after the snapshot edge
        en        = 4'hF;
        period_in = {pw(0, 0, 1000), pw(0, 0, 30000), pw(0, 1, 2), pw(0, 0, 6000)};
        pulse(k);
        push({32'h80000C00, 32'h80000066, 32'hC0177000, 32'h80000200}, k, 137);
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1 period_in = {$urandom, $urandom, $urandom, $urandom};
        end
        wait_done(400);

        // reset mid-sweep
        set_t1();
        pulse(k);
        repeat (50) @(posedge clk);
        #1;
        chk("pre_rst_ch0", vel_out[31:0], 32'hC00003E8);
        reset = 1'b0;
        #1;
        chk("midrst_vel", {31'd0, |vel_out}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_valid", {31'd0, vel_valid}, 32'd0);
        chk("midrst_ovr", {24'd0, overrun_cnt}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (150) @(posedge clk);
        pulse(k);
        push(EXP_T1, k, 137);
        wait_done(400);

        // saturation instance: NUMERATOR = 0xFFFFFFFF
        sat_per[0] = pw(0, 1, 1); sat_exp[0] = 32'hFFFFFFFF;
        sat_per[1] = pw(0, 0, 4); sat_exp[1] = 32'hBFFFFFFF;
        sat_per[2] = pw(0, 0, 5); sat_exp[2] = 32'hB3333333;
        for (int v = 0; v < 3; v++) begin
            period2 = sat_per[v];
            q2.push_back(sat_exp[v]);
            exp_valid2++;
            @(posedge clk); #1 sample2 = 1'b1;
            @(posedge clk); #1 sample2 = 1'b0;
            for (int n = 0; n < 100 && n_valid2 < exp_valid2; n++) @(negedge clk);
            if (n_valid2 < exp_valid2) chk("timeout_sat", n_valid2, exp_valid2);
            @(negedge clk);
        end

        repeat (5) @(posedge clk);
        chk("q_drained", q1.size() + q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
